// File: rtl/dependence_arbiter.sv
// dependence_arbiter
// Round-robin arbiter that shares a single evaluator of b & (a | c) among
// NUM_REQ requesters. The winner's result is held in a one-entry registered
// buffer tagged with the winning requester id.
// Optional feature macro: DEPENDENCE_ARB_OPSEL_EN adds a per-requester op
// select (req_op in, rsp_op out); op 1 evaluates a & b instead.
module dependence_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0] req_c,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_q,
  output logic [IDW-1:0]     rsp_id,
`ifdef DEPENDENCE_ARB_OPSEL_EN
  input  logic [NUM_REQ-1:0] req_op,
  output logic               rsp_op,
`endif
  output logic               busy
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic           res_q, res_d;
  logic [IDW-1:0] win_s;
  logic           found_s;
  logic           can_accept_s;
  logic           accept_s;
  logic           op_sel_s;
`ifdef DEPENDENCE_ARB_OPSEL_EN
  logic           op_q, op_d;
`endif

  // Shared evaluation unit; op 1 selects the alternate a & b function.
  function automatic logic eval_fn(input logic a, input logic b,
                                   input logic c, input logic op);
    logic r;
    if (op) begin
      r = a & b;
    end else begin
      r = b & (a | c);
    end
    return r;
  endfunction

  // Round-robin scan: first valid requester at or after ptr, wrapping.
  always_comb begin : p_scan
    int             idx;
    logic [IDW-1:0] idx_w;
    logic           hit;
    idx     = 0;
    idx_w   = {IDW{1'b0}};
    hit     = 1'b0;
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      idx     = int'(ptr_q) + k;
      idx     = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      idx_w   = IDW'(idx);
      hit     = req_valid[idx_w] & ~found_s;
      win_s   = hit ? idx_w : win_s;
      found_s = found_s | req_valid[idx_w];
    end
  end

  // The buffer can take a result when empty or when it drains this cycle.
  assign can_accept_s = (state_q == S_EMPTY) | rsp_ready;
  // Reset holds off every grant so req_ready reads zero while rst is high.
  assign accept_s     = found_s & can_accept_s & ~rst;

`ifdef DEPENDENCE_ARB_OPSEL_EN
  assign op_sel_s = req_op[win_s];
`else
  assign op_sel_s = 1'b0;
`endif

  // One-hot grant to the scan winner when an accept happens this cycle.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (accept_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Buffer next-state, result capture and pointer advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    res_d   = res_q;
    id_d    = id_q;
`ifdef DEPENDENCE_ARB_OPSEL_EN
    op_d    = op_q;
`endif
    case (state_q)
      S_EMPTY: state_d = accept_s ? S_FULL : S_EMPTY;
      // Drain with a simultaneous refill stays FULL, so no bubble appears.
      S_FULL:  state_d = (accept_s | ~rsp_ready) ? S_FULL : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (accept_s) begin
      res_d = eval_fn(req_a[win_s], req_b[win_s], req_c[win_s], op_sel_s);
      id_d  = win_s;
      ptr_d = (int'(win_s) == NUM_REQ - 1) ? {IDW{1'b0}} : (win_s + IDW'(1'b1));
`ifdef DEPENDENCE_ARB_OPSEL_EN
      op_d  = op_sel_s;
`endif
    end else begin
      res_d = res_q;
      id_d  = id_q;
      ptr_d = ptr_q;
    end
  end

  // State registers; reset empties the buffer and rewinds the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= {IDW{1'b0}};
      res_q   <= 1'b0;
      id_q    <= {IDW{1'b0}};
`ifdef DEPENDENCE_ARB_OPSEL_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      res_q   <= res_d;
      id_q    <= id_d;
`ifdef DEPENDENCE_ARB_OPSEL_EN
      op_q    <= op_d;
`endif
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_q     = res_q;
  assign rsp_id    = id_q;
  assign busy      = rsp_valid | (|req_valid);
`ifdef DEPENDENCE_ARB_OPSEL_EN
  assign rsp_op    = op_q;
`endif

endmodule

// File: tb/tb_dependence_arbiter.sv
// Testbench for dependence_arbiter (default build, NUM_REQ = 4).
// A transaction-level reference model (pointer, one-entry result slot) is
// advanced once per rising edge and predicts every visible output.
module tb_dependence_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int EW = N + IW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, req_a, req_b, req_c;
  logic          rsp_valid, rsp_ready, rsp_q, busy;
  logic [IW-1:0] rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_valid, m_q, m_id, m_ptr, m_last_acc;
  logic [EW-1:0] got_v, exp_v;

  dependence_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // First valid requester scanning upward from the model pointer, or -1.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Expected {rsp_valid, rsp_q, rsp_id, req_ready, busy} for current inputs.
  function automatic logic [EW-1:0] model_outs();
    int w = model_winner();
    logic [N-1:0] rdy = '0;
    logic bz;
    if (w >= 0 && (m_valid == 0 || rsp_ready)) rdy[w] = 1'b1;
    bz = (m_valid != 0) || (req_valid != '0);
    return {m_valid[0], m_q[0], m_id[IW-1:0], rdy, bz};
  endfunction

  // Advance the model across one rising edge using the current inputs.
  function automatic void model_clock();
    int w = model_winner();
    m_last_acc = -1;
    if (w >= 0 && (m_valid == 0 || rsp_ready)) begin
      m_valid    = 1;
      m_q        = int'(req_b[w] & (req_a[w] | req_c[w]));
      m_id       = w;
      m_ptr      = (w + 1) % N;
      m_last_acc = w;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
  endfunction

  function automatic void model_reset();
    m_valid = 0; m_q = 0; m_id = 0; m_ptr = 0; m_last_acc = -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_clock();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    rsp_ready = 1'b0; model_reset();
    @(negedge clk);
    req_valid = 4'hF; #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_during_rst: got %b expected 0000", req_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_q, rsp_id, busy} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_outputs_during_rst: got %b expected 00001", {rsp_valid, rsp_q, rsp_id, busy});
    end
    @(negedge clk);
    req_valid = '0; rst = 1'b0; #1;
    n_checks++;
    got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy};
    if (got_v !== {EW{1'b0}}) begin
      n_fail++; $display("FAIL reset_idle: got %b expected all zero", got_v);
    end
    model_clock();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      req_a = 4'b0100; req_b = (t == 0) ? 4'b0100 : 4'b0000; req_c = (t == 0) ? 4'b0000 : 4'b0100;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
        n_fail++; $display("FAIL single_grant t%0d: got %b expected 0100", t, req_ready);
      end
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL single_model_grant t%0d: got %b expected %b", t, got_v, exp_v);
      end
      model_clock();
      @(negedge clk);
      req_valid = '0; #1;
      n_checks++;
      if ({rsp_valid, rsp_q, rsp_id} !== {1'b1, (t == 0) ? 1'b1 : 1'b0, 2'd2}) begin
        n_fail++; $display("FAIL single_result t%0d: got %b expected %b", t, {rsp_valid, rsp_q, rsp_id}, {1'b1, (t == 0) ? 1'b1 : 1'b0, 2'd2});
      end
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL single_model_result t%0d: got %b expected %b", t, got_v, exp_v);
      end
      model_clock();
    end
  endtask

  // Pointer sits at 3 after requester 2 was granted; only 0 and 1 request.
  task automatic test_wrap();
    logic [N-1:0] exp_rdy [3] = '{4'b0001, 4'b0010, 4'b0000};
    logic [N-1:0] vld     [3] = '{4'b0011, 4'b0010, 4'b0000};
    rsp_ready = 1'b1;
    req_a = 4'h3; req_b = 4'h3; req_c = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = vld[k]; #1;
      n_checks++;
      if (req_ready !== exp_rdy[k]) begin
        n_fail++; $display("FAIL wrap_grant step%0d: got %b expected %b", k, req_ready, exp_rdy[k]);
      end
      if (k > 0) begin
        n_checks++;
        if ({rsp_valid, rsp_id} !== {1'b1, IW'(k - 1)}) begin
          n_fail++; $display("FAIL wrap_id step%0d: got %b expected %b", k, {rsp_valid, rsp_id}, {1'b1, IW'(k - 1)});
        end
      end
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL wrap_model step%0d: got %b expected %b", k, got_v, exp_v);
      end
      model_clock();
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req_a = N'($urandom); req_b = N'($urandom); req_c = N'($urandom);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'hF; #1;
      n_checks++;
      if (req_ready !== (4'b0001 << order[k])) begin
        n_fail++; $display("FAIL rr_grant step%0d: got %b expected %b", k, req_ready, 4'b0001 << order[k]);
      end
      if (k > 0) begin
        n_checks++;
        if ({rsp_valid, rsp_id} !== {1'b1, IW'(order[k-1])}) begin
          n_fail++; $display("FAIL rr_id step%0d: got %b expected %b", k, {rsp_valid, rsp_id}, {1'b1, IW'(order[k-1])});
        end
      end
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL rr_model step%0d: got %b expected %b", k, got_v, exp_v);
      end
      model_clock();
    end
  endtask

  // Buffer holds id 0, pointer at 1; all four keep requesting.
  task automatic test_backpressure();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = (k == 5) ? 4'h0 : 4'hF;
      rsp_ready = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      #1;
      if (k >= 1 && k <= 3) begin
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id} !== {4'b0000, 1'b1, 2'd1}) begin
          n_fail++; $display("FAIL bp_stall step%0d: got %b expected %b", k, {req_ready, rsp_valid, rsp_id}, {4'b0000, 1'b1, 2'd1});
        end
      end else if (k == 4) begin
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id} !== {4'b0100, 1'b1, 2'd1}) begin
          n_fail++; $display("FAIL bp_refill: got %b expected %b", {req_ready, rsp_valid, rsp_id}, {4'b0100, 1'b1, 2'd1});
        end
      end else if (k == 5) begin
        n_checks++;
        if ({rsp_valid, rsp_id} !== {1'b1, 2'd2}) begin
          n_fail++; $display("FAIL bp_after_refill: got %b expected %b", {rsp_valid, rsp_id}, {1'b1, 2'd2});
        end
      end
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL bp_model step%0d: got %b expected %b", k, got_v, exp_v);
      end
      model_clock();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 4'b0001; req_a = 4'hF; req_b = 4'hF; req_c = 4'h0; rsp_ready = 1'b1; #1;
    model_clock();
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b0; #1;
    got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL rstmid_full: got %b expected %b", got_v, exp_v);
    end
    #1 rst = 1'b1; model_reset();
    #1;
    n_checks++;
    if ({rsp_valid, rsp_q, rsp_id} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_async_clear: got %b expected 0000", {rsp_valid, rsp_q, rsp_id});
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b1010; rsp_ready = 1'b1; #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %b expected 0010", req_ready);
    end
    model_clock();
    @(negedge clk);
    req_valid = 4'b1000; #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id} !== {4'b1000, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL rstmid_second: got %b expected %b", {req_ready, rsp_valid, rsp_id}, {4'b1000, 1'b1, 2'd1});
    end
    got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
    if (got_v !== exp_v) begin
      n_fail++; $display("FAIL rstmid_model: got %b expected %b", got_v, exp_v);
    end
    model_clock();
    @(negedge clk);
    req_valid = '0; #1;
    model_clock();
  endtask

  // Random traffic; pending requesters keep valid and operands until granted.
  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_last_acc == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i]     = 1'($urandom_range(0, 1));
          req_b[i]     = 1'($urandom_range(0, 1));
          req_c[i]     = 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      got_v = {rsp_valid, rsp_q, rsp_id, req_ready, busy}; exp_v = model_outs(); n_checks++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random_model cyc%0d: got %b expected %b", cyc, got_v, exp_v);
      end
      model_clock();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
